exc_commit_ctrl: RTL and testbench



---
 rtl/exc_commit_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_ctrl.sv
// MEM-stage exception/ERET commit sequencer: prioritises causes, drains the data bus,
// strobes CP0 once, then flushes the pipeline and redirects fetch.
module exc_commit_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter int          DRAIN_MAX  = 15,
   parameter int          DRAIN_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [6:0]  mem_exc,
   input  logic        mem_eret,
   input  logic [31:0] mem_pc,
   input  logic        mem_in_ds,
   input  logic [31:0] mem_bad_addr,
   input  logic        int_pending,
   input  logic        status_exl,
   input  logic [31:0] epc_in,
   input  logic        bus_busy,
   output logic        mem_kill,
   output logic        stall,
   output logic        cp0_exc_we,
   output logic        cp0_epc_we,
   output logic        cp0_badv_we,
   output logic [4:0]  cp0_exccode,
   output logic [31:0] cp0_epc,
   output logic        cp0_bd,
   output logic [31:0] cp0_badvaddr,
   output logic        cp0_eret_we,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        drain_timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_COMMIT,
      S_REDIRECT
   } state_t;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;

   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX);

   state_t             state;
   state_t             state_nxt;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DRAIN_W-1:0] drain_cnt_inc;
   logic               drain_done;
   logic               drain_expired;

   logic               int_eff;
   logic               exc_hit;
   logic               event_hit;
   logic [4:0]         dec_code;
   logic               dec_badv_we;
   logic [31:0]        dec_badv;

   logic               kind_exc_q;
   logic [4:0]         code_q;
   logic [31:0]        epc_q;
   logic               bd_q;
   logic [31:0]        badv_q;
   logic               badv_we_q;
   logic               epc_we_q;

   // Cause priority: a masked-in interrupt beats every synchronous cause, and any
   // cause beats an ERET carried by the same instruction.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      int_eff     = int_pending & ~status_exl;
      exc_hit     = int_eff | (|mem_exc);
      event_hit   = mem_valid & (exc_hit | mem_eret);
      dec_code    = EXC_INT;
      dec_badv_we = 1'b0;
      dec_badv    = '0;
      if (int_eff) begin
         dec_code = EXC_INT;
      end else if (mem_exc[6]) begin
         dec_code    = EXC_ADEL;
         dec_badv_we = 1'b1;
         dec_badv    = mem_pc;
      end else if (mem_exc[5]) begin
         dec_code = EXC_RI;
      end else if (mem_exc[4]) begin
         dec_code = EXC_OV;
      end else if (mem_exc[3]) begin
         dec_code = EXC_SYS;
      end else if (mem_exc[2]) begin
         dec_code = EXC_BP;
      end else if (mem_exc[1]) begin
         dec_code    = EXC_ADEL;
         dec_badv_we = 1'b1;
         dec_badv    = mem_bad_addr;
      end else if (mem_exc[0]) begin
         dec_code    = EXC_ADES;
         dec_badv_we = 1'b1;
         dec_badv    = mem_bad_addr;
      end
   end

   always_comb begin
      state_nxt      = state;
      drain_cnt_inc  = drain_cnt + DRAIN_W'(1);
      drain_expired  = bus_busy & (drain_cnt_inc == DRAIN_LAST);
      drain_done     = ~bus_busy | drain_expired;
      mem_kill       = 1'b0;
      stall          = 1'b0;
      cp0_exc_we     = 1'b0;
      cp0_epc_we     = 1'b0;
      cp0_badv_we    = 1'b0;
      cp0_eret_we    = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (state)
         S_IDLE: begin
            // The kill must land in the same cycle so the faulting access never issues.
            mem_kill = rst & event_hit & exc_hit;
            if (event_hit) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            stall = 1'b1;
            if (drain_done) state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            stall       = 1'b1;
            cp0_exc_we  = kind_exc_q;
            cp0_epc_we  = kind_exc_q & epc_we_q;
            cp0_badv_we = kind_exc_q & badv_we_q;
            cp0_eret_we = ~kind_exc_q;
            state_nxt   = S_REDIRECT;
         end
         S_REDIRECT: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = kind_exc_q ? EXC_VECTOR : epc_in;
            state_nxt      = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the latched cause fields are plain flops, so they are reset with the FSM.
      if (!rst) begin
         state         <= S_IDLE;
         drain_cnt     <= '0;
         drain_timeout <= 1'b0;
         kind_exc_q    <= 1'b0;
         code_q        <= '0;
         epc_q         <= '0;
         bd_q          <= 1'b0;
         badv_q        <= '0;
         badv_we_q     <= 1'b0;
         epc_we_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (event_hit) begin
                  drain_cnt  <= '0;
                  kind_exc_q <= exc_hit;
                  code_q     <= dec_code;
                  epc_q      <= mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
                  bd_q       <= mem_in_ds;
                  badv_we_q  <= dec_badv_we;
                  epc_we_q   <= ~status_exl;
                  if (dec_badv_we) badv_q <= dec_badv;
               end
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt_inc;
               if (drain_expired) drain_timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cp0_exccode  = code_q;
   assign cp0_epc      = epc_q;
   assign cp0_bd       = bd_q;
   assign cp0_badvaddr = badv_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Randomised bench for exc_commit_ctrl; expectations come from a transaction-level
// model of the commit timeline (event, drain length, commit, redirect).
module tb_exc_commit_ctrl;

   localparam logic [31:0] VEC = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_valid, mem_eret, mem_in_ds, int_pending, status_exl, bus_busy;
   logic [6:0]  mem_exc;
   logic [31:0] mem_pc, mem_bad_addr, epc_in;
   logic        mem_kill, stall, cp0_exc_we, cp0_epc_we, cp0_badv_we, cp0_bd, cp0_eret_we;
   logic        flush, redirect_valid, drain_timeout;
   logic [4:0]  cp0_exccode;
   logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;

   int n_checks = 0;
   int n_errors = 0;
   logic sticky = 1'b0;

   exc_commit_ctrl dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_exc(mem_exc), .mem_eret(mem_eret),
      .mem_pc(mem_pc), .mem_in_ds(mem_in_ds), .mem_bad_addr(mem_bad_addr),
      .int_pending(int_pending), .status_exl(status_exl), .epc_in(epc_in), .bus_busy(bus_busy),
      .mem_kill(mem_kill), .stall(stall), .cp0_exc_we(cp0_exc_we), .cp0_epc_we(cp0_epc_we),
      .cp0_badv_we(cp0_badv_we), .cp0_exccode(cp0_exccode), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
      .cp0_badvaddr(cp0_badvaddr), .cp0_eret_we(cp0_eret_we), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .drain_timeout(drain_timeout)
   );

   always #5 clk = ~clk;

   // {mem_kill, stall, exc_we, epc_we, badv_we, eret_we, flush, redirect_valid}
   wire [7:0] ctrl = {mem_kill, stall, cp0_exc_we, cp0_epc_we, cp0_badv_we,
                      cp0_eret_we, flush, redirect_valid};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Cause model: walk the causes in priority order, first hit wins.
   function automatic void ref_cause(input logic int_eff, input logic [6:0] exc,
                                     input logic [31:0] pc, input logic [31:0] bad,
                                     output logic is_exc, output logic [4:0] code,
                                     output logic bwe, output logic [31:0] badv);
      is_exc = int_eff || (exc != 7'd0);
      code   = 5'h00;
      bwe    = 1'b0;
      badv   = 32'd0;
      if (!int_eff) begin
         for (int b = 6; b >= 0; b--) begin
            if (exc[b]) begin
               case (b)
                  6: begin code = 5'h04; bwe = 1'b1; badv = pc; end
                  5: code = 5'h0A;
                  4: code = 5'h0C;
                  3: code = 5'h08;
                  2: code = 5'h09;
                  1: begin code = 5'h04; bwe = 1'b1; badv = bad; end
                  default: begin code = 5'h05; bwe = 1'b1; badv = bad; end
               endcase
               break;
            end
         end
      end
   endfunction

   // Inputs outside IDLE must be ignored, so they are scrambled there.
   task automatic drive_junk();
      mem_valid    = 1'($urandom);
      mem_exc      = 7'($urandom);
      mem_eret     = 1'($urandom);
      mem_pc       = $urandom;
      mem_in_ds    = 1'($urandom);
      mem_bad_addr = $urandom;
      int_pending  = 1'($urandom);
      status_exl   = 1'($urandom);
      epc_in       = $urandom;
   endtask

   task automatic drive_quiet();
      drive_junk();
      if (mem_valid) begin
         mem_exc     = 7'd0;
         mem_eret    = 1'b0;
         int_pending = 1'b0;
      end
      bus_busy = 1'($urandom);
   endtask

   // busy_n: cycles bus_busy is held high, counted from the event cycle.
   task automatic run_event(input string nm, input logic v_int, input logic exl,
                            input logic [6:0] exc, input logic eret, input logic [31:0] pc,
                            input logic in_ds, input logic [31:0] bad, input int busy_n,
                            input logic [31:0] epc_val);
      logic        is_exc, bwe;
      logic [4:0]  code;
      logic [31:0] badv, epc_exp;
      int          dlen;
      ref_cause(v_int & ~exl, exc, pc, bad, is_exc, code, bwe, badv);
      epc_exp = in_ds ? pc - 32'd4 : pc;
      dlen = (busy_n < 1) ? 1 : ((busy_n > 15) ? 15 : busy_n);

      @(posedge clk); #1;
      mem_valid = 1'b1; mem_exc = exc; mem_eret = eret; mem_pc = pc; mem_in_ds = in_ds;
      mem_bad_addr = bad; int_pending = v_int; status_exl = exl; epc_in = $urandom;
      bus_busy = (busy_n > 0);
      @(negedge clk);
      check({nm, ".event_ctrl"}, ctrl, {is_exc, 7'd0});

      for (int i = 0; i < dlen; i++) begin
         @(posedge clk); #1;
         drive_junk();
         bus_busy = (i + 1 < busy_n);
         @(negedge clk);
         check({nm, ".drain_ctrl"}, ctrl, 8'b0100_0000);
         check({nm, ".drain_tmo"}, drain_timeout, sticky);
      end
      if (busy_n > 15) sticky = 1'b1;

      @(posedge clk); #1;
      drive_junk();
      bus_busy = 1'($urandom);
      @(negedge clk);
      check({nm, ".commit_ctrl"}, ctrl,
            {1'b0, 1'b1, is_exc, is_exc & ~exl, is_exc & bwe, ~is_exc, 2'b00});
      check({nm, ".commit_tmo"}, drain_timeout, sticky);
      if (is_exc) begin
         check({nm, ".code"}, cp0_exccode, code);
         check({nm, ".epc"}, cp0_epc, epc_exp);
         check({nm, ".bd"}, cp0_bd, in_ds);
         if (bwe) check({nm, ".badv"}, cp0_badvaddr, badv);
      end

      @(posedge clk); #1;
      drive_junk();
      epc_in = epc_val;
      @(negedge clk);
      check({nm, ".redir_ctrl"}, ctrl, 8'b0000_0011);
      check({nm, ".redir_pc"}, redirect_pc, is_exc ? VEC : epc_val);

      @(posedge clk); #1;
      drive_quiet();
      mem_valid = 1'b0;
      @(negedge clk);
      check({nm, ".post_ctrl"}, ctrl, 8'd0);
      check({nm, ".post_tmo"}, drain_timeout, sticky);
   endtask

   initial begin
      logic        r_int, r_exl, r_eret, r_ds;
      logic [6:0]  r_exc;
      int          r_busy;

      drive_junk();
      mem_valid = 1'b1;
      mem_exc   = 7'h10;
      bus_busy  = 1'b1;
      #12;
      check("rst.ctrl", ctrl, 8'd0);
      check("rst.code", cp0_exccode, 5'd0);
      check("rst.epc", cp0_epc, 32'd0);
      check("rst.badv", cp0_badvaddr, 32'd0);
      check("rst.redir_pc", redirect_pc, 32'd0);
      check("rst.tmo", drain_timeout, 1'b0);
      @(negedge clk);
      drive_quiet();
      mem_valid = 1'b0;
      rst = 1'b1;

      run_event("ov", 0, 0, 7'b0010000, 0, 32'hBFC00100, 0, 32'h0, 0, 32'h0);
      run_event("sys_ds", 0, 0, 7'b0001000, 0, 32'hBFC00204, 1, 32'h0, 0, 32'h0);
      run_event("ades", 0, 0, 7'b0000001, 0, 32'hBFC00300, 0, 32'h80000003, 3, 32'h0);
      run_event("int_ov", 1, 0, 7'b0010000, 0, 32'hBFC00400, 0, 32'h0, 0, 32'h0);
      run_event("int_ov_exl", 1, 1, 7'b0010000, 0, 32'hBFC00400, 0, 32'h0, 0, 32'h0);
      run_event("eret", 0, 0, 7'b0000000, 1, 32'hBFC00500, 0, 32'h0, 0, 32'h80001000);
      run_event("pcadel_ri", 0, 0, 7'b1100010, 1, 32'hBFC00601, 0, 32'h1234, 1, 32'h0);
      run_event("drain14", 0, 0, 7'b0000010, 0, 32'hBFC00700, 0, 32'h80000002, 15, 32'h0);
      run_event("timeout", 0, 0, 7'b0000100, 0, 32'hBFC00800, 1, 32'h0, 20, 32'h0);
      run_event("sticky", 0, 0, 7'b0000100, 0, 32'hBFC00900, 0, 32'h0, 0, 32'h0);

      for (int n = 0; n < 80; n++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            drive_quiet();
            @(negedge clk);
            check("quiet.ctrl", ctrl, 8'd0);
         end
         do begin
            r_int  = 1'($urandom);
            r_exl  = 1'($urandom);
            r_eret = 1'($urandom);
            case ($urandom_range(0, 2))
               0: r_exc = 7'd0;
               1: r_exc = 7'(1 << $urandom_range(0, 6));
               default: r_exc = 7'($urandom);
            endcase
         end while (!((r_int & ~r_exl) | (|r_exc) | r_eret));
         r_ds   = 1'($urandom);
         r_busy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 18))
                                              : int'($urandom_range(0, 5));
         run_event("rand", r_int, r_exl, r_exc, r_eret, $urandom, r_ds, $urandom, r_busy,
                   $urandom);
      end

      // Reset in the middle of a long drain.
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_exc = 7'b0000001; mem_eret = 1'b0; int_pending = 1'b0;
      status_exl = 1'b0; mem_bad_addr = 32'hDEAD0000; bus_busy = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         drive_junk();
         bus_busy = 1'b1;
      end
      @(negedge clk);
      check("middrain.ctrl", ctrl, 8'b0100_0000);
      #2 rst = 1'b0;
      #1;
      sticky = 1'b0;
      check("midrst.ctrl", ctrl, 8'd0);
      check("midrst.tmo", drain_timeout, 1'b0);
      check("midrst.code", cp0_exccode, 5'd0);
      check("midrst.badv", cp0_badvaddr, 32'd0);
      @(posedge clk); #2;
      mem_valid = 1'b0;
      rst = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         drive_quiet();
         mem_valid = 1'b0;
         bus_busy  = 1'b1;
         @(negedge clk);
         check("postrst.ctrl", ctrl, 8'd0);
         check("postrst.tmo", drain_timeout, 1'b0);
      end
      run_event("after_rst", 0, 0, 7'b0100000, 0, 32'hBFC00A04, 1, 32'h0, 2, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
